// File: rtl/matrix_mul_pkg.sv
// Shared constants and helpers for the matrix_mul 4x4 matrix-vector multiplier.
// Optional build macro MATRIX_MUL_SATURATE_EN is consumed in matrix_mul_dot4.
package matrix_mul_pkg;

  // Matrix dimension: 4 rows, 4 columns, 4 vector elements.
  localparam int unsigned DIM = 4;

  // Row sum width: a 2N-bit product summed DIM (=4) times needs 2 extra bits.
  function automatic int unsigned sum_width(input int unsigned n);
    return 2 * n + 2;
  endfunction

  // Bit offset of element j (0-based) within a packed row {e0,e1,e2,e3};
  // element 0 sits in the MSBs.
  function automatic int unsigned elem_lsb(input int unsigned n, input int unsigned j);
    return (DIM - 1 - j) * n;
  endfunction

endpackage

// File: rtl/matrix_mul_if.sv
// Data bundle for matrix_mul: packed matrix rows, vector elements and results.
// The slave side (the multiplier) samples A/X every clock and drives Y.
interface matrix_mul_if #(
  parameter int unsigned N = 4
);

  logic [4*N-1:0] A1;
  logic [4*N-1:0] A2;
  logic [4*N-1:0] A3;
  logic [4*N-1:0] A4;
  logic [N-1:0]   X1;
  logic [N-1:0]   X2;
  logic [N-1:0]   X3;
  logic [N-1:0]   X4;
  logic [2*N-1:0] Y1;
  logic [2*N-1:0] Y2;
  logic [2*N-1:0] Y3;
  logic [2*N-1:0] Y4;

  modport master (
    output A1, A2, A3, A4,
    output X1, X2, X3, X4,
    input  Y1, Y2, Y3, Y4
  );

  modport slave (
    input  A1, A2, A3, A4,
    input  X1, X2, X3, X4,
    output Y1, Y2, Y3, Y4
  );

endinterface

// File: rtl/matrix_mul_dot4.sv
// One matrix row: four registered products, adder tree, registered result.
// MATRIX_MUL_SATURATE_EN selects clamping instead of wrap-around on overflow.
module matrix_mul_dot4
  import matrix_mul_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             preset,
  input  logic [DIM*N-1:0] row,
  input  logic [DIM*N-1:0] xv,
  output logic [2*N-1:0]   y
);

  localparam int unsigned PW = 2 * N;
  localparam int unsigned SW = sum_width(N);

  logic [PW-1:0] p [DIM];
  logic [SW-1:0] sum;
  logic [PW-1:0] y_next;

  // Stage 1: products keep loading during preset; only clear zeroes them.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      for (int unsigned j = 0; j < DIM; j++) begin
        p[j] <= '0;
      end
    end else begin
      for (int unsigned j = 0; j < DIM; j++) begin
        p[j] <= PW'(row[elem_lsb(N, j) +: N]) * PW'(xv[elem_lsb(N, j) +: N]);
      end
    end
  end

  always_comb begin
    sum = '0;
    for (int unsigned j = 0; j < DIM; j++) begin
      sum = sum + SW'(p[j]);
    end
  end

`ifdef MATRIX_MUL_SATURATE_EN
  always_comb begin
    y_next = PW'(sum);
    if (sum[SW-1:PW] != '0) begin
      y_next = '1;
    end
  end
`else
  always_comb begin
    y_next = PW'(sum);
  end
`endif

  // Stage 2: clear beats preset.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      y <= '0;
    end else if (!preset) begin
      y <= '1;
    end else begin
      y <= y_next;
    end
  end

endmodule

// File: rtl/matrix_mul.sv
// Unsigned 4x4 matrix times 4-element vector, two-stage pipeline, one result per clock.
// Build option MATRIX_MUL_SATURATE_EN clamps row sums that exceed 2N bits.
module matrix_mul
  import matrix_mul_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic        clk,
  input  logic        clear,
  input  logic        preset,
  matrix_mul_if.slave bus
);

  logic [DIM*N-1:0] rows [DIM];
  logic [DIM*N-1:0] xv;
  logic [2*N-1:0]   ys   [DIM];

  assign rows[0] = bus.A1;
  assign rows[1] = bus.A2;
  assign rows[2] = bus.A3;
  assign rows[3] = bus.A4;

  // Vector packed in the same order as a row so the same element helper applies.
  assign xv = {bus.X1, bus.X2, bus.X3, bus.X4};

  for (genvar i = 0; i < DIM; i++) begin : g_row
    matrix_mul_dot4 #(
      .N (N)
    ) u_dot4 (
      .clk    (clk),
      .clear  (clear),
      .preset (preset),
      .row    (rows[i]),
      .xv     (xv),
      .y      (ys[i])
    );
  end

  assign bus.Y1 = ys[0];
  assign bus.Y2 = ys[1];
  assign bus.Y3 = ys[2];
  assign bus.Y4 = ys[3];

endmodule

// File: tb/tb_matrix_mul.sv
// Directed self-checking bench for matrix_mul with N=4 (hand-computed expectations).
// Honours MATRIX_MUL_SATURATE_EN for the overflow vector.
module tb_matrix_mul;

  localparam int unsigned N = 4;

  logic clk;
  logic clear;
  logic preset;
  int   checks;
  int   errors;

  matrix_mul_if #(.N(N)) bus ();

  matrix_mul #(
    .N (N)
  ) dut (
    .clk    (clk),
    .clear  (clear),
    .preset (preset),
    .bus    (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic chk_y(input string tag, input logic [31:0] e1, input logic [31:0] e2,
                       input logic [31:0] e3, input logic [31:0] e4);
    chk({tag, ".Y1"}, 32'(bus.Y1), e1);
    chk({tag, ".Y2"}, 32'(bus.Y2), e2);
    chk({tag, ".Y3"}, 32'(bus.Y3), e3);
    chk({tag, ".Y4"}, 32'(bus.Y4), e4);
  endtask

  task automatic set_rows(input logic [15:0] r1, input logic [15:0] r2,
                          input logic [15:0] r3, input logic [15:0] r4);
    bus.A1 = r1;
    bus.A2 = r2;
    bus.A3 = r3;
    bus.A4 = r4;
  endtask

  task automatic set_x(input logic [3:0] x1, input logic [3:0] x2,
                       input logic [3:0] x3, input logic [3:0] x4);
    bus.X1 = x1;
    bus.X2 = x2;
    bus.X3 = x3;
    bus.X4 = x4;
  endtask

  task automatic set_random;
    set_rows(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
    set_x(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
  endtask

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "tb_matrix_mul timeout");
  end

  initial begin
    int unsigned ovf;
    checks = 0;
    errors = 0;
    clear  = 1'b1;
    preset = 1'b1;
    set_random();

    // asynchronous clear, checked between clock edges
    #2 clear = 1'b0;
    #1 chk_y("rst_async", 0, 0, 0, 0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk_y("rst_held", 0, 0, 0, 0);
      set_random();
    end

    // basic: rows {1,2,3,4}, X all ones -> 10
    set_rows(16'h1234, 16'h1234, 16'h1234, 16'h1234);
    set_x(4'd1, 4'd1, 4'd1, 4'd1);
    clear = 1'b1;
    @(negedge clk);
    chk_y("rel_edge1", 0, 0, 0, 0);
    @(negedge clk);
    chk_y("basic", 10, 10, 10, 10);

    // identity, back-to-back vectors
    set_rows(16'h1000, 16'h0100, 16'h0010, 16'h0001);
    set_x(4'd1, 4'd2, 4'd3, 4'd4);
    @(negedge clk);
    set_x(4'd5, 4'd6, 4'd7, 4'd8);
    @(negedge clk);
    chk_y("ident_a", 1, 2, 3, 4);
    @(negedge clk);
    chk_y("ident_b", 5, 6, 7, 8);

    // overflow: 4*15*15 = 900 = 0x384
`ifdef MATRIX_MUL_SATURATE_EN
    ovf = 255;
`else
    ovf = 132;
`endif
    set_rows(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    set_x(4'd15, 4'd15, 4'd15, 4'd15);
    @(negedge clk);
    @(negedge clk);
    chk_y("overflow", ovf, ovf, ovf, ovf);

    // mixed rows: {1,2,3,4}.X=(4,3,2,1) -> 20, {15,0,0,1}.X -> 61, {0,0,0,0}->0, {2,2,2,2}->20
    set_rows(16'h1234, 16'hF001, 16'h0000, 16'h2222);
    set_x(4'd4, 4'd3, 4'd2, 4'd1);
    @(negedge clk);
    @(negedge clk);
    chk_y("mixed", 20, 61, 0, 20);

    // preset: Y forced to all ones while products keep loading
    set_rows(16'h1111, 16'h1111, 16'h1111, 16'h1111);
    set_x(4'd2, 4'd2, 4'd2, 4'd2);
    preset = 1'b0;
    @(negedge clk);
    chk_y("preset", 255, 255, 255, 255);
    preset = 1'b1;
    @(negedge clk);
    chk_y("post_preset", 8, 8, 8, 8);

    // clear pulse mid-cycle
    @(posedge clk);
    #2 clear = 1'b0;
    #1 chk_y("clr_mid", 0, 0, 0, 0);
    @(negedge clk);
    chk_y("clr_hold", 0, 0, 0, 0);
    clear = 1'b1;
    @(negedge clk);
    chk_y("clr_rel1", 0, 0, 0, 0);
    @(negedge clk);
    chk_y("clr_rel2", 8, 8, 8, 8);

    // clear dominates preset
    clear  = 1'b0;
    preset = 1'b0;
    #1 chk_y("both_low", 0, 0, 0, 0);
    @(negedge clk);
    chk_y("both_low_edge", 0, 0, 0, 0);
    clear  = 1'b1;
    preset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk_y("recover", 8, 8, 8, 8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
